// File: rtl/rv32_fetch_unit.sv
// RV32 fetch front end: owns the PC, issues imem reads and buffers {pc, instr} pairs for decode.
// Optional FETCH_HALT_ON_ZERO_EN: a returned zero word stops fetching until a redirect or reset.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst,
    output logic [31:0] instr_addr_o,
    output logic        instr_req_o,
    input  logic [31:0] instr_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        f_valid_o,
    input  logic        f_ready_i,
    output logic [31:0] f_instr_o,
    output logic [31:0] f_pc_o,
    output logic        fault_o,
    output logic        halt_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [31:0]   pc_q, pc_d, pc_prev_q;
    logic          live_q, inflight_q, fault_q, halt_q;
    logic [CW-1:0] count_q, count_d, occ;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   buf_instr_q [BUF_DEPTH];
    logic [31:0]   buf_pc_q    [BUF_DEPTH];
    logic          word_ok, push, pop;

    assign f_valid_o    = rst & ~redirect_i & (count_q != '0);
    assign pop          = f_valid_o & f_ready_i;
    assign push         = inflight_q & word_ok;
    // Occupancy counts the word already in flight so its slot is always reserved.
    assign occ          = count_q + CW'(inflight_q) - CW'(pop);
    assign instr_req_o  = rst & live_q & ~redirect_i & ~halt_q & (occ < DEPTH_C);
    assign instr_addr_o = pc_q;
    assign pc_d         = pc_q + 32'd4;
    assign count_d      = count_q + CW'(push) - CW'(pop);
    assign f_instr_o    = buf_instr_q[rd_ptr_q];
    assign f_pc_o       = buf_pc_q[rd_ptr_q];
    assign fault_o      = rst & fault_q;
    assign halt_o       = rst & halt_q;

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            pc_prev_q  <= RESET_PC;
            live_q     <= 1'b0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            live_q <= 1'b1;
            if (redirect_i) begin
                pc_q       <= {redirect_pc_i[31:2], 2'b00};
                inflight_q <= 1'b0;
                fault_q    <= |redirect_pc_i[1:0];
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                fault_q    <= 1'b0;
                inflight_q <= instr_req_o;
                count_q    <= count_d;
                if (instr_req_o) begin
                    pc_q      <= pc_d;
                    pc_prev_q <= pc_q;
                end
                if (push) begin
                    buf_instr_q[wr_ptr_q] <= instr_data_i;
                    buf_pc_q[wr_ptr_q]    <= pc_prev_q;
                    wr_ptr_q              <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

`ifdef FETCH_HALT_ON_ZERO_EN
    // Once halted, late responses (request issued the cycle the zero arrived) are dropped.
    assign word_ok = ~halt_q & (instr_data_i != 32'h0);

    always_ff @(posedge clk_i) begin
        if (!rst || redirect_i) begin
            halt_q <= 1'b0;
        end else if (inflight_q && !halt_q && instr_data_i == 32'h0) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign word_ok = 1'b1;
    assign halt_q  = 1'b0;
`endif

endmodule
